// File: rtl/if_id_skid_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : rv32i_pkg
//  Description : RV32I constants shared by the IF/ID pipeline register:
//                canonical NOP encoding and default payload widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int DEF_DPW  = 32;
    localparam int DEF_AW   = 32;
    localparam int DEF_CNTW = 8;

endpackage : rv32i_pkg
`default_nettype wire

// File: rtl/if_id_skid_reg_if.sv
`default_nettype none
// ============================================================================
//  Interface   : if_id_skid_reg_if
//  Description : Valid/ready instruction stream (instr, pc, pc+4).
//                master drives the payload, slave returns ready.
//  Revision    : 1.0 - initial release
// ============================================================================
interface if_id_skid_reg_if
    import rv32i_pkg::*;
#(
    parameter int DPW = DEF_DPW,
    parameter int AW  = DEF_AW
) ();

    logic           valid;
    logic           ready;
    logic [DPW-1:0] instr;
    logic [AW-1:0]  pc;
    logic [AW-1:0]  pcplus4;

    modport master (output valid, output instr, output pc, output pcplus4, input  ready);
    modport slave  (input  valid, input  instr, input  pc, input  pcplus4, output ready);

endinterface : if_id_skid_reg_if
`default_nettype wire

// File: rtl/if_id_skid_reg_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_buf
//  Description : Generic two-entry valid/ready pipeline register (main output
//                register plus one skid register). in_ready comes straight
//                from a flop so there is no ready path from out to in.
//                flush synchronously drops both entries and any input.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_buf #(
    parameter int W = 32
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         flush,
    input  wire logic         in_valid,
    output logic              in_ready,
    input  wire logic [W-1:0] in_data,
    output logic              out_valid,
    input  wire logic         out_ready,
    output logic [W-1:0]      out_data,
    output logic              skid_full
);

    logic         r_main_valid;
    logic [W-1:0] r_main_data;
    logic         r_skid_valid;
    logic [W-1:0] r_skid_data;

    logic w_in_fire;
    logic w_main_load;

    // main may take new data when it is empty or being consumed this cycle
    assign w_in_fire   = in_valid && !r_skid_valid;
    assign w_main_load = !r_main_valid || out_ready;

    // entry storage: main refills from skid first, then from input; a blocked input parks in skid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_load) begin
            if (r_skid_valid) begin
                r_main_data  <= r_skid_data;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_in_fire) begin
                r_main_data  <= in_data;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            r_skid_data  <= in_data;
            r_skid_valid <= 1'b1;
        end
    end

    assign in_ready  = !r_skid_valid;
    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;
    assign skid_full = r_skid_valid;

endmodule : pipe_skid_buf
`default_nettype wire

// File: rtl/if_id_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_skid_reg
//  Description : IF/ID pipeline register with skid buffer. Packs the fetch
//                payload into pipe_skid_buf, presents NOP on the decode side
//                whenever no entry is valid, and counts effective flushes.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_skid_reg
    import rv32i_pkg::*;
#(
    parameter int DPW  = DEF_DPW,
    parameter int AW   = DEF_AW,
    parameter int CNTW = DEF_CNTW
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    input  wire logic           flush,
    if_id_skid_reg_if.slave     in_if,
    if_id_skid_reg_if.master    out_if,
    output logic                skid_full,
    output logic [CNTW-1:0]     flush_cnt
);

    localparam int             c_w       = DPW + 2 * AW;
    localparam logic [DPW-1:0] c_nop     = DPW'(NOP_INSTR);
    localparam logic [CNTW-1:0] c_cnt_max = {CNTW{1'b1}};

    logic [c_w-1:0]  w_in_data;
    logic [c_w-1:0]  w_out_data;
    logic            w_out_valid;
    logic            w_skid_full;
    logic [CNTW-1:0] r_flush_cnt;

    assign w_in_data = {in_if.instr, in_if.pc, in_if.pcplus4};

    pipe_skid_buf #(
        .W (c_w)
    ) u_skid_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_if.valid),
        .in_ready  (in_if.ready),
        .in_data   (w_in_data),
        .out_valid (w_out_valid),
        .out_ready (out_if.ready),
        .out_data  (w_out_data),
        .skid_full (w_skid_full)
    );

    // pc fields simply hold the last main contents when invalid; instr is forced to NOP
    assign out_if.valid   = w_out_valid;
    assign out_if.instr   = w_out_valid ? w_out_data[c_w-1 -: DPW] : c_nop;
    assign out_if.pc      = w_out_data[2*AW-1 -: AW];
    assign out_if.pcplus4 = w_out_data[AW-1:0];
    assign skid_full      = w_skid_full;

    // saturating count of flushes that actually killed something
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush_cnt <= '0;
        end else if (flush && (w_out_valid || w_skid_full) && (r_flush_cnt != c_cnt_max)) begin
            r_flush_cnt <= r_flush_cnt + CNTW'(1);
        end
    end

    assign flush_cnt = r_flush_cnt;

endmodule : if_id_skid_reg
`default_nettype wire

// File: tb/tb_if_id_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_skid_reg
//  Description : Self-checking bench for if_id_skid_reg: directed vector
//                table, async reset and counter saturation sequences, and
//                randomized traffic against an occupancy-queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_skid_reg;

    localparam logic [31:0] c_nop = 32'h0000_0013;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       skid_full, skid_full2;
    logic [7:0] flush_cnt;
    logic [1:0] flush_cnt2;

    int tests  = 0;
    int failed = 0;

    if_id_skid_reg_if #(.DPW(32), .AW(32)) in_if ();
    if_id_skid_reg_if #(.DPW(32), .AW(32)) out_if ();
    if_id_skid_reg_if #(.DPW(32), .AW(32)) in2 ();
    if_id_skid_reg_if #(.DPW(32), .AW(32)) out2 ();

    always #5 clk = ~clk;

    if_id_skid_reg #(.DPW(32), .AW(32), .CNTW(8)) dut (
        .clk (clk), .rst_n (rst_n), .flush (flush),
        .in_if (in_if), .out_if (out_if),
        .skid_full (skid_full), .flush_cnt (flush_cnt)
    );

    // second instance with a 2-bit counter sees identical traffic
    assign in2.valid   = in_if.valid;
    assign in2.instr   = in_if.instr;
    assign in2.pc      = in_if.pc;
    assign in2.pcplus4 = in_if.pcplus4;
    assign out2.ready  = out_if.ready;

    if_id_skid_reg #(.DPW(32), .AW(32), .CNTW(2)) dut2 (
        .clk (clk), .rst_n (rst_n), .flush (flush),
        .in_if (in2), .out_if (out2),
        .skid_full (skid_full2), .flush_cnt (flush_cnt2)
    );

    // ---------------- reference model: queue of held pcs ----------------
    logic [31:0] mq[$];
    logic [31:0] m_last;
    int          m_cnt;

    function automatic logic [31:0] mk(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0000;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_last = '0;
        m_cnt  = 0;
    endtask

    task automatic model_step(input logic iv, input logic ordy, input logic fl, input logic [31:0] pc);
        int sz;
        sz = mq.size();
        if (fl) begin
            if (sz > 0) m_cnt++;
            mq.delete();
        end else begin
            if (sz > 0 && ordy) void'(mq.pop_front());
            if (iv && sz < 2) mq.push_back(pc);
        end
        if (mq.size() > 0) m_last = mq[0];
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model(input string tag);
        logic        ev;
        logic [31:0] epc;
        ev  = (mq.size() > 0);
        epc = m_last;
        chk({tag, "_ov"},   64'(out_if.valid),   64'(ev));
        chk({tag, "_ins"},  64'(out_if.instr),   64'(ev ? mk(epc) : c_nop));
        chk({tag, "_pc"},   64'(out_if.pc),      64'(epc));
        chk({tag, "_pc4"},  64'(out_if.pcplus4), 64'((mq.size() == 0 && epc == 0 && m_cnt == 0 && 0) ? 0 : epc + 32'd4));
        chk({tag, "_skid"}, 64'(skid_full),      64'(mq.size() == 2));
        chk({tag, "_rdy"},  64'(in_if.ready),    64'(mq.size() < 2));
        chk({tag, "_cnt"},  64'(flush_cnt),      64'((m_cnt > 255) ? 255 : m_cnt));
        chk({tag, "_cnt2"}, 64'(flush_cnt2),     64'((m_cnt > 3) ? 3 : m_cnt));
    endtask

    // drive one cycle of inputs, let the edge happen, advance model
    task automatic cyc(input logic iv, input logic ordy, input logic fl, input logic [31:0] pc);
        in_if.valid   = iv;
        in_if.pc      = pc;
        in_if.instr   = mk(pc);
        in_if.pcplus4 = pc + 32'd4;
        out_if.ready  = ordy;
        flush         = fl;
        @(posedge clk);
        #1;
        model_step(iv, ordy, fl, pc);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ov"},   64'(out_if.valid),   64'd0);
        chk({tag, "_skid"}, 64'(skid_full),      64'd0);
        chk({tag, "_rdy"},  64'(in_if.ready),    64'd1);
        chk({tag, "_ins"},  64'(out_if.instr),   64'(c_nop));
        chk({tag, "_pc"},   64'(out_if.pc),      64'd0);
        chk({tag, "_pc4"},  64'(out_if.pcplus4), 64'd0);
        chk({tag, "_cnt"},  64'(flush_cnt),      64'd0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        iv, ordy, fl;
        logic [31:0] pc;
        logic        eov;
        logic [31:0] epc;
        logic        esk, erdy;
        logic [7:0]  ecnt;
    } vec_t;

    function automatic vec_t v(input logic iv, input logic ordy, input logic fl, input logic [31:0] pc,
                               input logic eov, input logic [31:0] epc, input logic esk,
                               input logic erdy, input logic [7:0] ecnt);
        vec_t r;
        r.iv = iv; r.ordy = ordy; r.fl = fl; r.pc = pc;
        r.eov = eov; r.epc = epc; r.esk = esk; r.erdy = erdy; r.ecnt = ecnt;
        return r;
    endfunction

    vec_t tbl[16];

    initial begin
        // streaming with decode always ready
        tbl[0]  = v(1, 1, 0, 32'h100, 1, 32'h100, 0, 1, 0);
        tbl[1]  = v(1, 1, 0, 32'h104, 1, 32'h104, 0, 1, 0);
        tbl[2]  = v(1, 1, 0, 32'h108, 1, 32'h108, 0, 1, 0);
        tbl[3]  = v(0, 1, 0, 32'h0,   0, 32'h108, 0, 1, 0);
        // stall: A in main, B in skid, C refused until release
        tbl[4]  = v(1, 0, 0, 32'h200, 1, 32'h200, 0, 1, 0);
        tbl[5]  = v(1, 0, 0, 32'h204, 1, 32'h200, 1, 0, 0);
        tbl[6]  = v(1, 0, 0, 32'h208, 1, 32'h200, 1, 0, 0);
        tbl[7]  = v(1, 1, 0, 32'h208, 1, 32'h204, 0, 1, 0);
        tbl[8]  = v(1, 1, 0, 32'h208, 1, 32'h208, 0, 1, 0);
        tbl[9]  = v(0, 1, 0, 32'h0,   0, 32'h208, 0, 1, 0);
        // flush with both entries full and a new input presented
        tbl[10] = v(1, 0, 0, 32'h300, 1, 32'h300, 0, 1, 0);
        tbl[11] = v(1, 0, 0, 32'h304, 1, 32'h300, 1, 0, 0);
        tbl[12] = v(1, 0, 1, 32'h308, 0, 32'h300, 0, 1, 1);
        tbl[13] = v(0, 0, 1, 32'h0,   0, 32'h300, 0, 1, 1);
        tbl[14] = v(1, 1, 0, 32'h30C, 1, 32'h30C, 0, 1, 1);
        tbl[15] = v(0, 1, 0, 32'h0,   0, 32'h30C, 0, 1, 1);

        in_if.valid = 0; in_if.pc = 0; in_if.instr = 0; in_if.pcplus4 = 0;
        out_if.ready = 0; flush = 0;
        model_reset();

        // asynchronous reset at start
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_reset_vals("por");
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            string t;
            t = $sformatf("tbl%0d", i);
            cyc(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].pc);
            chk({t, "_ov"},   64'(out_if.valid),   64'(tbl[i].eov));
            chk({t, "_ins"},  64'(out_if.instr),   64'(tbl[i].eov ? mk(tbl[i].epc) : c_nop));
            chk({t, "_pc"},   64'(out_if.pc),      64'(tbl[i].epc));
            chk({t, "_pc4"},  64'(out_if.pcplus4), 64'(tbl[i].epc + 32'd4));
            chk({t, "_skid"}, 64'(skid_full),      64'(tbl[i].esk));
            chk({t, "_rdy"},  64'(in_if.ready),    64'(tbl[i].erdy));
            chk({t, "_cnt"},  64'(flush_cnt),      64'(tbl[i].ecnt));
        end

        // reset pulsed mid-stream with skid full
        cyc(1, 0, 0, 32'h400);
        cyc(1, 0, 0, 32'h404);
        chk("pre_rst_skid", 64'(skid_full), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("mid_rst");
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1, 1, 0, 32'h500);
        chk("post_rst_ov",  64'(out_if.valid), 64'd1);
        chk("post_rst_pc",  64'(out_if.pc),    64'h500);
        chk("post_rst_skid", 64'(skid_full),   64'd0);
        cyc(0, 1, 0, 32'h0);
        chk("post_rst_alone", 64'(out_if.valid), 64'd0);
        chk("post_rst_nop",   64'(out_if.instr), 64'(c_nop));

        // five effective flushes: 8-bit counter reaches 5, 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, 32'h600 + 32'(i * 8));
            cyc(0, 0, 1, 32'h0);
        end
        cyc(0, 0, 1, 32'h0);
        chk("sat_cnt8", 64'(flush_cnt),  64'd5);
        chk("sat_cnt2", 64'(flush_cnt2), 64'd3);
        cmp_model("sat");

        // randomized traffic against the queue model
        for (int i = 0; i < 10000; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 15) == 0), 32'h1_0000 + 32'(i * 4));
            cmp_model("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_if_id_skid_reg
`default_nettype wire
